lcd_access_sequencer: RTL and testbench

Parametrised message and access sequencer for the alcohol-check door. It debounces the presence, sound (blow) and alcohol inputs, then runs the access state machine with configurable hold times and a repeated-denial lockout. It drives the relay grant and serves the 2x16 character buffer through an addressed read port, so the LCD driver fetches characters instead of taking 32 parallel registers. It sits between the sensor blocks and the LCD driver.

---
 rtl/lcd_access_sequencer_if.sv | 24 ++
 rtl/lcd_access_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_lcd_access_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/lcd_access_sequencer_if.sv
// LCD character read port of the access sequencer.
// The LCD driver (master) presents a character index and fetches the
// character of the current message one cycle later. It also watches msg_id
// and msg_update to know when the screen must be redrawn.
interface lcd_access_sequencer_if;
    logic [4:0] char_addr;
    logic [8:0] char_data;
    logic [2:0] msg_id;
    logic       msg_update;

    modport master (
        output char_addr,
        input  char_data,
        input  msg_id,
        input  msg_update
    );

    modport slave (
        input  char_addr,
        output char_data,
        output msg_id,
        output msg_update
    );
endinterface

// File: rtl/lcd_access_sequencer.sv
// Access sequencer for the alcohol-check door.
// Sensor flags are synchronised and debounced before they reach the access
// FSM. The FSM times the GRANTED/DENIED result screens and locks the door
// after repeated denials. A small character ROM serves the 2x16 text of the
// current message through the LCD read port.
module lcd_access_sequencer #(
    parameter int HOLD_CYCLES    = 500_000_000,
    parameter int DEB_CYCLES     = 500_000,
    parameter int MAX_DENY       = 3,
    parameter int LOCK_CYCLES    = 1_000_000_000,
    parameter int CNT_W          = 31,
    parameter int ALC_ACTIVE_LOW = 1
) (
    input  logic                         CLOCK_50,
    input  logic                         iRST,
    input  logic                         presence_in,
    input  logic                         sound_in,
    input  logic                         alcohol_in,
    output logic                         grant,
    output logic                         locked,
    output logic [2:0]                   deny_cnt,
    lcd_access_sequencer_if.slave        lcd
);

    // The state code doubles as the message number shown on the LCD.
    typedef enum logic [2:0] {
        S_READY   = 3'd0,
        S_AWAY    = 3'd1,
        S_DENIED  = 3'd2,
        S_GRANTED = 3'd3,
        S_LOCKED  = 3'd4
    } state_t;

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [2:0]       DENY_LAST = 3'(MAX_DENY - 1);
    localparam logic [2:0]       DENY_MAX  = 3'(MAX_DENY);

    localparam int IDX_PRES  = 0;
    localparam int IDX_SOUND = 1;
    localparam int IDX_ALC   = 2;

    localparam logic [127:0] LINE_BLANK = "                ";
    localparam logic [127:0] L0A = "   BIENVENIDO   ";
    localparam logic [127:0] L0B = "SOPLE POR FAVOR ";
    localparam logic [127:0] L1A = "   POR FAVOR    ";
    localparam logic [127:0] L1B = "ACERQUESE MEJOR ";
    localparam logic [127:0] L2A = "ALCOHOL PRESENTE";
    localparam logic [127:0] L2B = " ACCESO DENEGADO";
    localparam logic [127:0] L3A = "  SIN ALCOHOL   ";
    localparam logic [127:0] L3B = "ACCESO CONCEDIDO";
    localparam logic [127:0] L4A = "     WARNING    ";
    localparam logic [127:0] L4B = "      !!!!      ";

    logic [2:0]       w_rawIn;
    logic [2:0]       r_meta;
    logic [2:0]       r_sync;
    logic [2:0]       r_deb;
    logic [DEB_W-1:0] r_debCnt [3];
    logic             r_soundPrev;
    logic             w_presence;
    logic             w_soundEdge;
    logic             w_alcDet;

    state_t           r_state;
    state_t           r_prevMsg;
    logic [CNT_W-1:0] r_timer;
    logic             r_grant;
    logic             r_locked;
    logic [2:0]       r_denyCnt;
    logic             r_rstPend;
    logic             r_msgUpdate;

    logic [127:0]     w_line;
    logic [3:0]       w_col;
    logic [7:0]       w_ascii;
    logic [8:0]       r_charData;

    assign w_rawIn     = {alcohol_in, sound_in, presence_in};
    assign w_presence  = r_deb[IDX_PRES];
    assign w_soundEdge = r_deb[IDX_SOUND] & ~r_soundPrev;
    assign w_alcDet    = (ALC_ACTIVE_LOW != 0) ? ~r_deb[IDX_ALC] : r_deb[IDX_ALC];

    // Two-flop synchroniser followed by a debouncer per sensor input; any
    // cycle of agreement restarts the stability count.
    always_ff @(posedge CLOCK_50) begin
        if (iRST) begin
            r_meta      <= '0;
            r_sync      <= '0;
            r_deb       <= '0;
            r_soundPrev <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                r_debCnt[k] <= '0;
            end
        end else begin
            r_meta      <= w_rawIn;
            r_sync      <= r_meta;
            r_soundPrev <= r_deb[IDX_SOUND];
            for (int k = 0; k < 3; k++) begin
                if (r_sync[k] != r_deb[k]) begin
                    if (r_debCnt[k] == DEB_LAST) begin
                        r_deb[k]    <= r_sync[k];
                        r_debCnt[k] <= '0;
                    end else begin
                        r_debCnt[k] <= r_debCnt[k] + 1'b1;
                    end
                end else begin
                    r_debCnt[k] <= '0;
                end
            end
        end
    end

    // Access FSM with registered grant/locked/deny count and the hold timer.
    always_ff @(posedge CLOCK_50) begin
        if (iRST) begin
            r_state   <= S_AWAY;
            r_timer   <= '0;
            r_grant   <= 1'b0;
            r_locked  <= 1'b0;
            r_denyCnt <= '0;
        end else begin
            case (r_state)
                S_AWAY: begin
                    r_timer <= '0;
                    if (w_presence) begin
                        r_state <= S_READY;
                    end
                end
                S_READY: begin
                    r_timer <= '0;
                    if (!w_presence) begin
                        r_state <= S_AWAY;
                    end else if (w_soundEdge) begin
                        if (!w_alcDet) begin
                            r_state   <= S_GRANTED;
                            r_grant   <= 1'b1;
                            r_denyCnt <= '0;
                        end else if (r_denyCnt < DENY_LAST) begin
                            r_state   <= S_DENIED;
                            r_denyCnt <= r_denyCnt + 3'd1;
                        end else begin
                            r_state   <= S_LOCKED;
                            r_locked  <= 1'b1;
                            r_denyCnt <= DENY_MAX;
                        end
                    end
                end
                S_GRANTED: begin
                    if (!w_presence || r_timer == HOLD_LAST) begin
                        r_state <= w_presence ? S_READY : S_AWAY;
                        r_grant <= 1'b0;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DENIED: begin
                    if (r_timer == HOLD_LAST) begin
                        r_state <= w_presence ? S_READY : S_AWAY;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (r_timer == LOCK_LAST) begin
                        r_state   <= w_presence ? S_READY : S_AWAY;
                        r_locked  <= 1'b0;
                        r_denyCnt <= '0;
                        r_timer   <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_AWAY;
                    r_timer  <= '0;
                    r_grant  <= 1'b0;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    // Refresh pulse: once after reset release and one cycle after each message change.
    always_ff @(posedge CLOCK_50) begin
        if (iRST) begin
            r_rstPend   <= 1'b1;
            r_prevMsg   <= S_AWAY;
            r_msgUpdate <= 1'b0;
        end else begin
            r_rstPend   <= 1'b0;
            r_prevMsg   <= r_state;
            r_msgUpdate <= r_rstPend | (r_state != r_prevMsg);
        end
    end

    // Select the text line of the current message addressed by char_addr.
    always_comb begin
        w_line = LINE_BLANK;
        case (r_state)
            S_READY:   w_line = lcd.char_addr[4] ? L0B : L0A;
            S_AWAY:    w_line = lcd.char_addr[4] ? L1B : L1A;
            S_DENIED:  w_line = lcd.char_addr[4] ? L2B : L2A;
            S_GRANTED: w_line = lcd.char_addr[4] ? L3B : L3A;
            S_LOCKED:  w_line = lcd.char_addr[4] ? L4B : L4A;
            default:   w_line = LINE_BLANK;
        endcase
    end

    // Column 0 is the leftmost (most significant) character of the line.
    assign w_col   = lcd.char_addr[3:0];
    assign w_ascii = w_line[{~w_col, 3'b000} +: 8];

    // Registered character read so the LCD driver sees a one-cycle latency.
    always_ff @(posedge CLOCK_50) begin
        if (iRST) begin
            r_charData <= 9'h120;
        end else begin
            r_charData <= {1'b1, w_ascii};
        end
    end

    assign grant          = r_grant;
    assign locked         = r_locked;
    assign deny_cnt       = r_denyCnt;
    assign lcd.msg_id     = r_state;
    assign lcd.msg_update = r_msgUpdate;
    assign lcd.char_data  = r_charData;

endmodule

// File: tb/tb_lcd_access_sequencer.sv
// Self-checking bench for the door access sequencer with short timings
// (hold 20, debounce 4, lockout after 2 denials, lockout 50 cycles).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_lcd_access_sequencer;

    typedef enum logic [2:0] {
        MSG_READY   = 3'd0,
        MSG_AWAY    = 3'd1,
        MSG_DENIED  = 3'd2,
        MSG_GRANTED = 3'd3,
        MSG_LOCKED  = 3'd4
    } msg_t;

    typedef struct {
        logic       pres;
        logic       snd;
        logic       alc;
        logic [4:0] addr;
        int         cycles;
        logic [2:0] expMsg;
        logic       expGrant;
        logic       expLocked;
        logic [2:0] expDeny;
        logic [8:0] expChar;
    } vec_t;

    logic       CLOCK_50    = 1'b0;
    logic       iRST        = 1'b1;
    logic       presence_in = 1'b0;
    logic       sound_in    = 1'b0;
    logic       alcohol_in  = 1'b1;
    logic       grant;
    logic       locked;
    logic [2:0] deny_cnt;

    int assertCount = 0;
    int failCount   = 0;
    int grantCycles;
    int pulseCount;

    vec_t vecs [14];

    lcd_access_sequencer_if lcdBus ();

    lcd_access_sequencer #(
        .HOLD_CYCLES    (20),
        .DEB_CYCLES     (4),
        .MAX_DENY       (2),
        .LOCK_CYCLES    (50),
        .CNT_W          (8),
        .ALC_ACTIVE_LOW (1)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .iRST        (iRST),
        .presence_in (presence_in),
        .sound_in    (sound_in),
        .alcohol_in  (alcohol_in),
        .grant       (grant),
        .locked      (locked),
        .deny_cnt    (deny_cnt),
        .lcd         (lcdBus.slave)
    );

    // 50 MHz-style free-running clock.
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic step(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        presence_in      = v.pres;
        sound_in         = v.snd;
        alcohol_in       = v.alc;
        lcdBus.char_addr = v.addr;
        step(v.cycles);
    endtask

    // Main stimulus sequence.
    initial begin
        lcdBus.char_addr = 5'd0;

        // Vector table: READY with alcohol -> DENIED, ignored presence drop,
        // AWAY, second denial -> LOCKED, lockout expiry, glitch, GRANTED.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 5'd3,  10, MSG_READY,   1'b0, 1'b0, 3'd0, 9'h142};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 5'd0,  8,  MSG_DENIED,  1'b0, 1'b0, 3'd1, 9'h141};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 5'd17, 8,  MSG_DENIED,  1'b0, 1'b0, 3'd1, 9'h141};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 5'd17, 12, MSG_AWAY,    1'b0, 1'b0, 3'd1, 9'h143};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 5'd4,  10, MSG_READY,   1'b0, 1'b0, 3'd1, 9'h149};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 5'd22, 9,  MSG_LOCKED,  1'b0, 1'b1, 3'd2, 9'h121};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 5'd22, 10, MSG_LOCKED,  1'b0, 1'b1, 3'd2, 9'h121};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 5'd22, 10, MSG_LOCKED,  1'b0, 1'b1, 3'd2, 9'h121};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 5'd22, 10, MSG_LOCKED,  1'b0, 1'b1, 3'd2, 9'h121};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 5'd22, 20, MSG_READY,   1'b0, 1'b0, 3'd0, 9'h150};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 5'd22, 10, MSG_READY,   1'b0, 1'b0, 3'd0, 9'h150};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 5'd22, 3,  MSG_READY,   1'b0, 1'b0, 3'd0, 9'h150};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 5'd22, 10, MSG_READY,   1'b0, 1'b0, 3'd0, 9'h150};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 5'd2,  10, MSG_GRANTED, 1'b1, 1'b0, 3'd0, 9'h153};

        // Reset values.
        step(3);
        checkOutput("rst msg_id",     32'(lcdBus.msg_id),     32'(MSG_AWAY));
        checkOutput("rst grant",      32'(grant),             32'd0);
        checkOutput("rst locked",     32'(locked),            32'd0);
        checkOutput("rst deny_cnt",   32'(deny_cnt),          32'd0);
        checkOutput("rst char_data",  32'(lcdBus.char_data),  32'h120);
        checkOutput("rst msg_update", 32'(lcdBus.msg_update), 32'd0);

        // Release: single refresh pulse.
        iRST = 1'b0;
        step(1);
        checkOutput("release pulse", 32'(lcdBus.msg_update), 32'd1);
        step(1);
        checkOutput("release pulse end", 32'(lcdBus.msg_update), 32'd0);

        // Presence arrives: AWAY -> READY after sync + debounce + FSM latency.
        presence_in      = 1'b1;
        lcdBus.char_addr = 5'd3;
        step(6);
        checkOutput("away before deb", 32'(lcdBus.msg_id),    32'(MSG_AWAY));
        checkOutput("away char P",     32'(lcdBus.char_data), 32'h150);
        step(1);
        checkOutput("ready msg_id",    32'(lcdBus.msg_id),     32'(MSG_READY));
        checkOutput("no early pulse",  32'(lcdBus.msg_update), 32'd0);
        step(1);
        checkOutput("ready pulse",     32'(lcdBus.msg_update), 32'd1);
        checkOutput("ready char B",    32'(lcdBus.char_data),  32'h142);
        pulseCount = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (lcdBus.msg_update) pulseCount++;
        end
        checkOutput("no extra pulses", 32'(pulseCount), 32'd0);

        // Sober blow: GRANTED for exactly HOLD cycles, then READY.
        lcdBus.char_addr = 5'd16;
        sound_in = 1'b1;
        step(7);
        checkOutput("granted msg_id", 32'(lcdBus.msg_id), 32'(MSG_GRANTED));
        checkOutput("granted grant",  32'(grant),         32'd1);
        grantCycles = 1;
        for (int i = 0; i < 30; i++) begin
            if (i == 2) sound_in = 1'b0;
            step(1);
            if (i == 0) checkOutput("granted char A", 32'(lcdBus.char_data), 32'h141);
            if (grant) grantCycles++;
        end
        checkOutput("grant length",     32'(grantCycles),       32'd20);
        checkOutput("post grant msg",   32'(lcdBus.msg_id),     32'(MSG_READY));
        checkOutput("post grant grant", 32'(grant),             32'd0);
        checkOutput("post grant deny",  32'(deny_cnt),          32'd0);
        checkOutput("ready char S",     32'(lcdBus.char_data),  32'h153);

        // Table-driven vectors.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d msg_id", i),    32'(lcdBus.msg_id),    32'(vecs[i].expMsg));
            checkOutput($sformatf("vec%0d grant", i),     32'(grant),            32'(vecs[i].expGrant));
            checkOutput($sformatf("vec%0d locked", i),    32'(locked),           32'(vecs[i].expLocked));
            checkOutput($sformatf("vec%0d deny_cnt", i),  32'(deny_cnt),         32'(vecs[i].expDeny));
            checkOutput($sformatf("vec%0d char_data", i), 32'(lcdBus.char_data), 32'(vecs[i].expChar));
        end

        // Presence drop in GRANTED: AWAY exactly DEB+3 cycles later.
        presence_in = 1'b0;
        step(6);
        checkOutput("drop still granted", 32'(lcdBus.msg_id), 32'(MSG_GRANTED));
        checkOutput("drop grant held",    32'(grant),         32'd1);
        step(1);
        checkOutput("drop away msg",      32'(lcdBus.msg_id), 32'(MSG_AWAY));
        checkOutput("drop grant off",     32'(grant),         32'd0);

        // Reset mid-GRANTED, then a held sound level must not decide.
        presence_in = 1'b1;
        sound_in    = 1'b0;
        step(10);
        checkOutput("pre rst ready", 32'(lcdBus.msg_id), 32'(MSG_READY));
        sound_in = 1'b1;
        step(10);
        checkOutput("pre rst granted", 32'(grant), 32'd1);
        iRST = 1'b1;
        step(1);
        checkOutput("mid rst grant",  32'(grant),             32'd0);
        checkOutput("mid rst msg_id", 32'(lcdBus.msg_id),     32'(MSG_AWAY));
        checkOutput("mid rst char",   32'(lcdBus.char_data),  32'h120);
        iRST = 1'b0;
        step(1);
        checkOutput("rst2 pulse", 32'(lcdBus.msg_update), 32'd1);
        step(29);
        checkOutput("held sound msg",   32'(lcdBus.msg_id), 32'(MSG_READY));
        checkOutput("held sound grant", 32'(grant),         32'd0);
        sound_in = 1'b0;
        step(10);
        sound_in = 1'b1;
        step(10);
        checkOutput("new edge granted", 32'(lcdBus.msg_id), 32'(MSG_GRANTED));
        checkOutput("new edge grant",   32'(grant),         32'd1);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
